serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 137 +++++++++++++
 tb/tb_serial_subtractor.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial WIDTH-bit subtractor computing a - b - bin, one
//                bit per clock, LSB first, with one full-subtractor cell and
//                a registered borrow. Start/done handshake for a controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res;
    logic               r_borrow;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_a_msb;
    logic               r_b_msb;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_ovf;

    logic               w_x;
    logic               w_y;
    logic               w_d;
    logic               w_borrow_next;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_next;

    // Full-subtractor cell on the current LSBs and the running borrow
    always_comb begin
        w_x           = r_a_sh[0];
        w_y           = r_b_sh[0];
        w_d           = w_x ^ w_y ^ r_borrow;
        w_borrow_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);
        w_res_next    = {w_d, r_res[WIDTH-1:1]};
        w_last        = (r_cnt == c_LAST);
    end

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: start is only honoured from IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand capture, serial shifting and final result write-back
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_borrow <= bin;
                        r_cnt    <= '0;
                        r_a_msb  <= a[WIDTH-1];
                        r_b_msb  <= b[WIDTH-1];
                    end
                end
                S_RUN: begin
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_borrow <= w_borrow_next;
                    r_res    <= w_res_next;
                    r_cnt    <= r_cnt + c_ONE;
                    // Visible outputs change only once the whole word is known
                    if (w_last) begin
                        r_diff <= w_res_next;
                        r_bout <= w_borrow_next;
                        r_ovf  <= (r_a_msb != r_b_msb) & (w_d != r_a_msb);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Self-checking bench for serial_subtractor (WIDTH=4) using a
//                result scoreboard and an independent integer reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int WIDTH = 4;

    logic             clock = 1'b0;
    logic             resetn;
    logic             start;
    logic [WIDTH-1:0] s_a;
    logic [WIDTH-1:0] s_b;
    logic             s_bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
    } exp_t;

    exp_t sb[$];

    serial_subtractor #(.WIDTH(WIDTH)) u_dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .a      (s_a),
        .b      (s_b),
        .bin    (s_bin),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .bout   (bout),
        .ovf    (ovf)
    );

    always #5 clock = ~clock;

    // Reference: unsigned 5-bit difference for diff/borrow, signed range for overflow
    function automatic exp_t model(input logic [3:0] ma, input logic [3:0] mb, input logic mbin);
        exp_t e;
        int   ua, ub, sa, sbv, sr, ur;
        ua  = int'(ma);
        ub  = int'(mb);
        ur  = ua - ub - int'(mbin);
        sa  = (ua >= 8) ? ua - 16 : ua;
        sbv = (ub >= 8) ? ub - 16 : ub;
        sr  = sa - sbv - int'(mbin);
        e.diff = 4'((ur + 16) % 16);
        e.bout = (ur < 0);
        e.ovf  = (sr < -8) || (sr > 7);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present operands with start high; the next rising edge accepts them
    task automatic issue(input logic [3:0] ia, input logic [3:0] ib, input logic ibin);
        @(negedge clock);
        s_a   = ia;
        s_b   = ib;
        s_bin = ibin;
        start = 1'b1;
        sb.push_back(model(ia, ib, ibin));
    endtask

    // Pop the oldest expected result and compare against the DUT outputs
    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_diff"}, 32'(diff), 32'(e.diff));
            check({tag, "_bout"}, 32'(bout), 32'(e.bout));
            check({tag, "_ovf"},  32'(ovf),  32'(e.ovf));
        end
    endtask

    // Wait for done after an accepting edge; lat counts negedges since acceptance
    task automatic wait_done(input string tag, input int lat0, input bit check_lat);
        int lat;
        int busy_cnt;
        bit seen;
        lat      = lat0;
        busy_cnt = lat0;
        seen     = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clock);
            if (lat == 0) start = 1'b0;
            lat++;
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (check_lat) begin
            check({tag, "_latency"}, 32'(lat), 32'(WIDTH + 1));
            check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH + 1));
        end
        check_result(tag);
    endtask

    // Confirm done was a single-cycle pulse and the block is back in IDLE
    task automatic check_after(input string tag);
        @(negedge clock);
        check({tag, "_done_low"}, 32'(done), 32'd0);
        check({tag, "_idle"},     32'(busy), 32'd0);
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        s_a    = '0;
        s_b    = '0;
        s_bin  = 1'b0;

        // Reset state
        @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        check("rst_ovf",  32'(ovf),  32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // Directed operations with explicit expected values
        issue(4'd9, 4'd3, 1'b0);
        wait_done("op_9m3", 0, 1'b1);
        check("op_9m3_diff_const", 32'(diff), 32'd6);
        check("op_9m3_ovf_const",  32'(ovf),  32'd1);
        check_after("op_9m3");

        issue(4'd3, 4'd9, 1'b0);
        wait_done("op_3m9", 0, 1'b1);
        check("op_3m9_diff_const", 32'(diff), 32'd10);
        check_after("op_3m9");

        issue(4'd5, 4'd5, 1'b1);
        wait_done("op_5m5b", 0, 1'b1);
        check("op_5m5b_bout_const", 32'(bout), 32'd1);
        check_after("op_5m5b");

        issue(4'd0, 4'd0, 1'b0);
        wait_done("op_zero", 0, 1'b1);
        check_after("op_zero");

        issue(4'd7, 4'd8, 1'b0);
        wait_done("op_7m8", 0, 1'b1);
        check("op_7m8_diff_const", 32'(diff), 32'd15);
        check_after("op_7m8");

        // Start held high; operands change during RUN and must not disturb op 1
        issue(4'd12, 4'd4, 1'b0);
        @(negedge clock);
        s_a = 4'd1;
        s_b = 4'd2;
        sb.push_back(model(4'd1, 4'd2, 1'b0));
        check("held_busy_run", 32'(busy), 32'd1);
        check("held_diff_holds", 32'(diff), 32'd15);
        wait_done("held_first", 1, 1'b1);
        check("held_first_diff_const", 32'(diff), 32'd8);
        check_after("held_first");
        wait_done("held_second", 0, 1'b1);
        check("held_second_diff_const", 32'(diff), 32'd15);
        check("held_second_bout_const", 32'(bout), 32'd1);
        check_after("held_second");

        // Asynchronous reset in the middle of a run
        @(negedge clock);
        s_a   = 4'd5;
        s_b   = 4'd3;
        s_bin = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("rst_mid_run1_diff_holds", 32'(diff), 32'd15);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_diff", 32'(diff), 32'd0);
        check("rst_mid_bout", 32'(bout), 32'd0);
        check("rst_mid_ovf",  32'(ovf),  32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check("rst_release_idle", 32'(busy), 32'd0);
        issue(4'd6, 4'd1, 1'b0);
        wait_done("post_rst", 0, 1'b1);
        check("post_rst_diff_const", 32'(diff), 32'd5);
        check_after("post_rst");

        // Exhaustive sweep of every operand/borrow-in combination
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            issue(v[3:0], v[7:4], v[8]);
            wait_done("sweep", 0, 1'b0);
            @(negedge clock);
        end

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run can never hang
    initial begin
        #2000000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
